ula_sequenciador: RTL

//  Clocked controller in front of the combinational ULA (4-bit ALU with 8 ops, O/C/Z/E flags).

---
 rtl/ula_sequenciador_pkg.sv | 29 ++
 rtl/ula_sequenciador_if.sv | 14 +
 rtl/contador_settle.sv | 25 ++
 rtl/ula.sv | 55 +++++
 rtl/ula_sequenciador.sv | 112 +++++++++++
 5 files changed

// File: rtl/ula_sequenciador_pkg.sv
// Shared op codes, FSM states and flag bit positions for the ULA sequencer and the ULA.
package ula_sequenciador_pkg;

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    localparam int FLG_O = 3;
    localparam int FLG_C = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_E = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } estado_t;

    // Only add/sub produce a carry that is meaningful for the next nibble.
    function automatic logic op_aritmetica(input logic [2:0] sel);
        return (sel == OP_SOMA) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// ULA operand/flag bus: master drives Sel/A/B/Cin, slave returns O/C/Z/E combinationally.
interface ula_sequenciador_if;
    logic [2:0] Sel;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       O_in;
    logic       C_in;
    logic       Z_in;
    logic       E_in;

    modport master (output Sel, A, B, Cin, input O_in, C_in, Z_in, E_in);
    modport slave  (input Sel, A, B, Cin, output O_in, C_in, Z_in, E_in);
endinterface

// File: rtl/contador_settle.sv
// Loadable down-counter with zero flag; load has priority over decrement, no backpressure.
module contador_settle #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/ula.sv
// Combinational 4-bit ALU (8 ops) returning overflow, carry/borrow, zero and error flags.
module ula
    import ula_sequenciador_pkg::*;
(
    ula_sequenciador_if.slave bus
);
    logic [4:0] soma_w;
    logic [4:0] sub_w;
    logic [7:0] prod_w;
    logic [3:0] res;
    logic       o_f;
    logic       c_f;
    logic       e_f;

    assign soma_w = {1'b0, bus.A} + {1'b0, bus.B} + {4'b0, bus.Cin};
    assign sub_w  = {1'b0, bus.A} - {1'b0, bus.B} - {4'b0, bus.Cin};
    assign prod_w = {4'b0, bus.A} * {4'b0, bus.B};

    always_comb begin
        res = '0;
        o_f = 1'b0;
        c_f = 1'b0;
        e_f = 1'b0;
        case (bus.Sel)
            OP_SOMA: begin
                res = soma_w[3:0];
                c_f = soma_w[4];
                o_f = (bus.A[3] == bus.B[3]) && (res[3] != bus.A[3]);
            end
            OP_SUB: begin
                res = sub_w[3:0];
                c_f = sub_w[4];
                o_f = (bus.A[3] != bus.B[3]) && (res[3] != bus.A[3]);
            end
            OP_MULT: begin
                res = prod_w[3:0];
                c_f = |prod_w[7:4];
                o_f = |prod_w[7:4];
            end
            OP_DIV: begin
                if (bus.B == 4'd0) e_f = 1'b1;
                else               res = bus.A / bus.B;
            end
            OP_AND:  res = bus.A & bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_XOR:  res = bus.A ^ bus.B;
            default: res = '0;
        endcase
    end

    assign bus.O_in = o_f;
    assign bus.C_in = c_f;
    assign bus.Z_in = (res == 4'd0) && !e_f;
    assign bus.E_in = e_f;
endmodule

// File: rtl/ula_sequenciador.sv
// Latches one command per start, holds ULA inputs SETTLE_CYCLES, captures flags; done at SETTLE_CYCLES+2.
// Starts arriving while busy are dropped (no queueing); a nop start only pulses rejected.
module ula_sequenciador
    import ula_sequenciador_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       cmd_sel,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             chain,
    input  logic             clr_carry,
    ula_sequenciador_if.master ula,
    output logic             busy,
    output logic             done,
    output logic             rejected,
    output logic [3:0]       flags_q,
    output logic             carry_q,
    output logic             err_sticky,
    output logic [CNT_W-1:0] op_count
);
    localparam int CW = $clog2(SETTLE_CYCLES) + 1;

    estado_t    state_q, state_d;
    logic       accept, reject, capture;
    logic       cnt_zero;
    logic [2:0] sel_q;
    logic [3:0] a_q, b_q;
    logic       cin_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (cmd_sel == OP_NOP)) begin
                    reject = 1'b1;
                end else if (start) begin
                    accept  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    contador_settle #(.W(CW)) u_contador (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (CW'(SETTLE_CYCLES - 1)),
        .dec_i      (state_q == ST_SETTLE),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= OP_NOP;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rejected   <= 1'b0;
            flags_q    <= '0;
            carry_q    <= 1'b0;
            err_sticky <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q  <= state_d;
            busy     <= (state_d != ST_IDLE);
            done     <= capture;
            rejected <= reject;
            if (accept) begin
                sel_q <= cmd_sel;
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                // A clear on the same cycle as start wins over chaining.
                cin_q <= chain & ~clr_carry & carry_q;
            end
            if ((state_q == ST_IDLE) && clr_carry) carry_q <= 1'b0;
            if (capture) begin
                flags_q[FLG_O] <= ula.O_in;
                flags_q[FLG_C] <= ula.C_in;
                flags_q[FLG_Z] <= ula.Z_in;
                flags_q[FLG_E] <= ula.E_in;
                carry_q        <= op_aritmetica(sel_q) & ula.C_in;
                err_sticky     <= err_sticky | ula.E_in;
                op_count       <= op_count + 1'b1;
            end
        end
    end

    assign ula.Sel = sel_q;
    assign ula.A   = a_q;
    assign ula.B   = b_q;
    assign ula.Cin = cin_q;
endmodule
